// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/city-road traffic controller.
// Holds the 2-bit light encoding, the FSM state enum and a small helper
// used to size the in-state timer from the duration parameters.
package traffic_pkg;

  localparam logic [1:0] LightRed    = 2'b00;
  localparam logic [1:0] LightYellow = 2'b01;
  localparam logic [1:0] LightGreen  = 2'b10;

  // Codes are visible on the debug state output, so keep them fixed.
  typedef enum logic [2:0] {
    HW_GREEN    = 3'd0,
    HW_YELLOW   = 3'd1,
    RED1        = 3'd2,
    CITY_GREEN  = 3'd3,
    CITY_YELLOW = 3'd4,
    RED2        = 3'd5,
    EMERG       = 3'd6
  } state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/traffic_timer.sv
// In-state cycle timer: synchronous clear, count-enable, saturates at all-ones.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset (count to 0)
//   clear_i  - force count to 0 on the next edge (wins over en_i)
//   en_i     - increment on the next edge unless saturated
//   count_o  - current count
module traffic_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_ctrl_param.sv
// Highway / city-road traffic light controller with pedestrian request and
// emergency override. Highway stays green until both its minimum dwell has
// elapsed and there is demand (enough waiting cars or a pending pedestrian),
// then runs a fixed yellow / all-red / city-green / yellow / all-red sequence.
// Ports:
//   clock     - single clock, rising edge
//   reset_n   - asynchronous active-low reset
//   carCount  - waiting cars on the city road
//   ped_req   - pedestrian request (pulse is enough, it is latched)
//   emerg     - emergency override, level-sensitive
//   Highway   - highway light (00 red, 01 yellow, 10 green)
//   Cityroad  - city-road light, same encoding
//   walk      - pedestrian walk, only during a served city-green
//   state     - current state code (debug)
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W  = 3,
  parameter int unsigned THRESH = 5,
  parameter int unsigned HW_MIN = 8,
  parameter int unsigned YEL_T  = 3,
  parameter int unsigned RED_T  = 1,
  parameter int unsigned CITY_T = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] carCount,
  input  logic             ped_req,
  input  logic             emerg,
  output logic [1:0]       Highway,
  output logic [1:0]       Cityroad,
  output logic             walk,
  output logic [2:0]       state
);

  localparam int unsigned MaxDur = max4(HW_MIN, YEL_T, RED_T, CITY_T);
  localparam int unsigned TimerW = $clog2(MaxDur) + 1;

  // Parameter legality, caught at elaboration.
  if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
    $fatal(1, "traffic_ctrl_param: CNT_W must be in 1..31");
  end
  if (THRESH < 1 || THRESH > ((1 << CNT_W) - 1)) begin : g_bad_thresh
    $fatal(1, "traffic_ctrl_param: THRESH must be in 1..2^CNT_W-1");
  end
  if (HW_MIN < 1 || YEL_T < 1 || RED_T < 1 || CITY_T < 1) begin : g_bad_dur
    $fatal(1, "traffic_ctrl_param: all durations must be >= 1");
  end

  // Last timer value of each dwell: the state is left on the edge where the
  // timer equals duration-1, giving exactly 'duration' cycles in state.
  localparam logic [TimerW-1:0] HwLast   = TimerW'(HW_MIN - 1);
  localparam logic [TimerW-1:0] YelLast  = TimerW'(YEL_T - 1);
  localparam logic [TimerW-1:0] RedLast  = TimerW'(RED_T - 1);
  localparam logic [TimerW-1:0] CityLast = TimerW'(CITY_T - 1);
  localparam logic [CNT_W-1:0]  Thresh   = CNT_W'(THRESH);

  state_e            state_q, state_d;
  logic              ped_pend_q, ped_pend_d;
  logic              walk_q, walk_d;
  logic [1:0]        hw_q, hw_d;
  logic [1:0]        city_q, city_d;
  logic [TimerW-1:0] timer;
  logic              entering;
  logic              car_req;

  traffic_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clear_i (entering),
    .en_i    (1'b1),
    .count_o (timer)
  );

  assign car_req = (carCount >= Thresh);

  always_comb begin
    state_d = state_q;
    case (state_q)
      HW_GREEN: begin
        if ((timer >= HwLast) && (car_req || ped_pend_q)) state_d = HW_YELLOW;
      end
      HW_YELLOW:   if (timer >= YelLast)  state_d = RED1;
      RED1:        if (timer >= RedLast)  state_d = CITY_GREEN;
      CITY_GREEN:  if (timer >= CityLast) state_d = CITY_YELLOW;
      CITY_YELLOW: if (timer >= YelLast)  state_d = RED2;
      RED2:        if (timer >= RedLast)  state_d = HW_GREEN;
      // Only reached with emerg low; the override below keeps us here otherwise.
      EMERG:       state_d = HW_GREEN;
      default:     state_d = HW_GREEN;
    endcase
    // Emergency beats every other condition, including a due transition.
    if (emerg) state_d = EMERG;
  end

  // Any state change restarts the timer, including EMERG -> HW_GREEN.
  assign entering = (state_d != state_q);

  always_comb begin
    // A request arriving on the entry edge survives to be served next time.
    ped_pend_d = ped_req ||
                 (ped_pend_q && !(entering && (state_d == CITY_GREEN)));
    // Walk is decided once at city-green entry and held for the dwell.
    walk_d = 1'b0;
    if (state_d == CITY_GREEN) begin
      walk_d = entering ? ped_pend_q : walk_q;
    end

    hw_d   = LightRed;
    city_d = LightRed;
    case (state_d)
      HW_GREEN:    hw_d   = LightGreen;
      HW_YELLOW:   hw_d   = LightYellow;
      CITY_GREEN:  city_d = LightGreen;
      CITY_YELLOW: city_d = LightYellow;
      default: begin
        hw_d   = LightRed;
        city_d = LightRed;
      end
    endcase
  end

  // Outputs are registered from the next-state decode, so they always match
  // the registered state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= HW_GREEN;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      hw_q       <= LightGreen;
      city_q     <= LightRed;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      hw_q       <= hw_d;
      city_q     <= city_d;
    end
  end

  assign Highway  = hw_q;
  assign Cityroad = city_q;
  assign walk     = walk_q;
  assign state    = state_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param with default parameters. Expected
// lights/walk are pushed into a scoreboard when each cycle's stimulus is
// driven and popped at the falling edge when the DUT outputs are sampled.
module tb_traffic_ctrl_param;

  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b00;

  typedef struct packed {
    logic [1:0] hw;
    logic [1:0] city;
    logic       walk;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic [2:0] carCount;
  logic       ped_req;
  logic       emerg;
  logic [1:0] Highway;
  logic [1:0] Cityroad;
  logic       walk;
  logic [2:0] state;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  traffic_ctrl_param dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .carCount (carCount),
    .ped_req  (ped_req),
    .emerg    (emerg),
    .Highway  (Highway),
    .Cityroad (Cityroad),
    .walk     (walk),
    .state    (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Nominal light pattern, k cycles after entering highway green with demand.
  function automatic logic [3:0] nom(input int k);
    if (k <= 7)       return {G, R};
    else if (k <= 10) return {Y, R};
    else if (k == 11) return {R, R};
    else if (k <= 17) return {R, G};
    else if (k <= 20) return {R, Y};
    else              return {R, R};
  endfunction

  task automatic check(input string tag, input int cyc_i, input logic [3:0] obs,
                       input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_i, obs, exp);
    end
  endtask

  // One cycle: drive inputs, push expectation, sample at negedge, compare.
  // Called just after a rising edge.
  task automatic cyc(input string tag, input int k, input logic [2:0] car, input logic ped,
                     input logic emg, input logic [3:0] lights, input logic wk);
    exp_t e;
    carCount = car;
    ped_req  = ped;
    emerg    = emg;
    e.hw     = lights[3:2];
    e.city   = lights[1:0];
    e.walk   = wk;
    sb.push_back(e);
    @(negedge clock);
    e = sb.pop_front();
    check({tag, ".hw"},   k, {2'b00, Highway},  {2'b00, e.hw});
    check({tag, ".city"}, k, {2'b00, Cityroad}, {2'b00, e.city});
    check({tag, ".walk"}, k, {3'b000, walk},    {3'b000, e.walk});
    @(posedge clock);
    #1;
  endtask

  // Assert reset between edges, check values appear without a clock edge,
  // then release just after a rising edge so the next edge is cycle 0.
  task automatic do_reset(input string tag);
    #2;
    reset_n  = 1'b0;
    carCount = '0;
    ped_req  = 1'b0;
    emerg    = 1'b0;
    #1;
    check({tag, ".rst_hw"},    -1, {2'b00, Highway},  {2'b00, G});
    check({tag, ".rst_city"},  -1, {2'b00, Cityroad}, {2'b00, R});
    check({tag, ".rst_walk"},  -1, {3'b000, walk},    4'd0);
    check({tag, ".rst_state"}, -1, {1'b0, state},     {1'b0, traffic_pkg::HW_GREEN});
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Never both green, checked every cycle out of reset.
  always @(negedge clock) begin
    if (reset_n) begin
      n_cmp++;
      assert (!(Highway == G && Cityroad == G)) else begin
        n_err++;
        $error("FAIL both_green at %0t: observed hw=%0h city=%0h required not both %0h",
               $time, Highway, Cityroad, G);
      end
    end
  end

  initial begin
    reset_n  = 1'b1;
    carCount = '0;
    ped_req  = 1'b0;
    emerg    = 1'b0;

    // Below threshold, no pedestrian: highway green forever.
    do_reset("idle");
    for (int k = 0; k < 40; k++) cyc("idle", k, 3'd2, 1'b0, 1'b0, {G, R}, 1'b0);

    // carCount exactly at threshold: full cycle, then highway green again.
    do_reset("thresh");
    for (int k = 0; k < 30; k++) cyc("thresh", k, 3'd5, 1'b0, 1'b0, nom(k % 22), 1'b0);

    // Below threshold but pedestrian pulse: same timing, walk in city green,
    // request consumed so highway then holds.
    do_reset("ped");
    for (int k = 0; k < 41; k++)
      cyc("ped", k, 3'd4, (k == 3), 1'b0, (k < 22) ? nom(k) : {G, R},
          (k >= 12 && k <= 17));

    // Emergency during city green for 5 cycles, then full highway dwell.
    do_reset("emerg");
    for (int k = 0; k < 32; k++) begin
      logic [3:0] l;
      if (k <= 14)      l = nom(k);
      else if (k <= 19) l = {R, R};
      else              l = nom(k - 20);
      cyc("emerg", k, 3'd5, (k == 2), (k >= 14 && k <= 18), l, (k >= 12 && k <= 14));
    end

    // Pedestrian request latched in city green, reset during city yellow:
    // immediate highway green and the request must be gone.
    do_reset("rstmid");
    for (int k = 0; k < 19; k++) cyc("rstmid", k, 3'd5, (k == 13), 1'b0, nom(k), 1'b0);
    check("rstmid.in_yellow", 19, {Highway, Cityroad}, {R, Y});
    do_reset("rstmid");
    for (int k = 0; k < 30; k++) cyc("rstmid_after", k, 3'd0, 1'b0, 1'b0, {G, R}, 1'b0);

    // Saturated demand: continuous 22-cycle period.
    do_reset("cont");
    for (int k = 0; k < 66; k++) cyc("cont", k, 3'd7, 1'b0, 1'b0, nom(k % 22), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
